left_checker_scan: RTL and testbench

Sequential row-serial constraint scanner for the maze datapath; the left-direction counterpart to the combinational right-constraint array. On a start pulse it walks the maze memory one row at a time, derives each row's left-move constraint vector from the cell and its right-hand neighbour, and writes the vector into the constraint store through a ready/valid write port. Only one row of logic is instantiated, at the cost of several cycles per row.

---
 rtl/left_checker_scan.sv | 114 +++++++++++
 tb/tb_left_checker_scan.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/left_checker_scan.sv
// left_checker_scan: row-serial scanner that derives each maze row's
// left-move constraint vector and writes it to the constraint store.
// One row of constraint logic is shared across all rows; each row costs
// a read, a capture and a write (plus any backpressure cycles).
module left_checker_scan #(
  parameter int size_y = 20,
  parameter int size_x = 40,
  parameter int AW     = $clog2(size_y)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  output logic              row_rd,
  output logic [AW-1:0]     row_addr,
  input  logic [0:size_x-1] row_data,
  output logic              cons_we,
  output logic [AW-1:0]     cons_addr,
  output logic [0:size_x-1] cons_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t              state;
  logic [AW-1:0]       row_cnt;
  logic [0:size_x-1]   row_buf;

  // A cell gets a left constraint when it is open and its right-hand
  // neighbour is a wall; the rightmost column has no neighbour.
  function automatic logic [0:size_x-1] left_cons(input logic [0:size_x-1] m);
    logic [0:size_x-1] c;
    c = '0;
    for (int x = 0; x < size_x - 1; x++) begin
      c[x] = ~m[x] & m[x+1];
    end
    return c;
  endfunction

  // Constraint data is decoded from the registered row buffer and only
  // driven while a write is being offered, so it reads 0 otherwise.
  always_comb begin
    cons_data = '0;
    if (cons_we) begin
      cons_data = left_cons(row_buf);
    end
  end

  // Scan sequencer: state, row counter, row buffer and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      row_cnt   <= '0;
      row_buf   <= '0;
      row_rd    <= 1'b0;
      row_addr  <= '0;
      cons_we   <= 1'b0;
      cons_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            row_cnt  <= '0;
            row_rd   <= 1'b1;
            row_addr <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          // Memory answers one cycle after the strobe, during CAPTURE.
          row_rd   <= 1'b0;
          row_addr <= '0;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          row_buf   <= row_data;
          cons_we   <= 1'b1;
          cons_addr <= row_cnt;
          state     <= WRITE;
        end
        WRITE: begin
          // Address and data stay put until the store takes the write.
          if (wr_ready) begin
            cons_we   <= 1'b0;
            cons_addr <= '0;
            if (row_cnt == AW'(size_y - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row_cnt  <= row_cnt + 1'b1;
              row_rd   <= 1'b1;
              row_addr <= row_cnt + 1'b1;
              state    <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_left_checker_scan.sv
// Bench for left_checker_scan: maze memory model, schedule-based reference
// model checked every cycle, plus directed scenarios with literal checks.
module tb_left_checker_scan;

  localparam int SY = 20;
  localparam int SX = 40;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic          row_rd;
  logic [AW-1:0] row_addr;
  logic [0:SX-1] row_data;
  logic          cons_we;
  logic [AW-1:0] cons_addr;
  logic [0:SX-1] cons_data;
  logic          wr_ready;
  logic          busy;
  logic          done;

  left_checker_scan #(.size_y(SY), .size_x(SX), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .row_rd(row_rd), .row_addr(row_addr), .row_data(row_data),
    .cons_we(cons_we), .cons_addr(cons_addr), .cons_data(cons_data),
    .wr_ready(wr_ready), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  logic [0:SX-1] mem [SY];
  logic [63:0]   junk;
  logic [63:0]   rnd;

  // Maze memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge Clk) begin
    junk = {$urandom, $urandom};
    if (row_rd) row_data <= mem[row_addr];
    else        row_data <= junk[SX-1:0];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // per-scan statistics gathered by the compare loop
  int start_cyc, done_cyc, wr_cnt, done_cnt, busy_cnt;
  logic [0:SX-1] got_cons [SY];
  bit            written  [SY];
  logic [AW+SX-1:0] seq[$];
  logic [AW+SX-1:0] seq_a[$];

  function automatic logic [0:SX-1] exp_cons(input logic [0:SX-1] m);
    logic [0:SX-1] c;
    c = '0;
    for (int x = 0; x <= SX - 2; x++)
      if (m[x] == 1'b0 && m[x+1] == 1'b1) c[x] = 1'b1;
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: after an accepted start, effective cycle e = (cycles since
  // start) - (backpressure cycles so far). Rows take 3 cycles each:
  // read at e=3r+1, write offered at e=3r+3; done at e=61; idle from e=62.
  task automatic compare_loop();
    bit m_active = 0;
    bit chk_en   = 0;
    int m_t = 0, m_stall = 0;
    forever begin
      int e, row, ph;
      logic          x_rd, x_we, x_busy, x_done;
      logic [AW-1:0] x_raddr, x_caddr;
      logic [0:SX-1] x_cdata;
      @(negedge Clk);
      cyc++;
      e = m_t - m_stall;
      x_rd = 0; x_we = 0; x_busy = 0; x_done = 0;
      x_raddr = '0; x_caddr = '0; x_cdata = '0;
      if (m_active && e >= 1 && e <= 3 * SY) begin
        x_busy = 1;
        row = (e - 1) / 3;
        ph  = (e - 1) % 3;
        if (ph == 0) begin x_rd = 1; x_raddr = AW'(row); end
        if (ph == 2) begin x_we = 1; x_caddr = AW'(row); x_cdata = exp_cons(mem[row]); end
      end
      if (m_active && e == 3 * SY + 1) x_done = 1;
      if (chk_en) begin
        chk("row_rd", row_rd, x_rd);
        chk("row_addr", row_addr, x_raddr);
        chk("cons_we", cons_we, x_we);
        chk("cons_addr", cons_addr, x_caddr);
        chk("cons_data", cons_data, x_cdata);
        chk("busy", busy, x_busy);
        chk("done", done, x_done);
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (cons_we === 1'b1 && wr_ready && !Reset) begin
          wr_cnt++;
          got_cons[cons_addr] = cons_data;
          written[cons_addr]  = 1;
          seq.push_back({cons_addr, cons_data});
        end
      end
      // advance the model to the next cycle
      if (Reset) begin
        m_active = 0;
        chk_en   = 1;
      end else if (chk_en) begin
        if (m_active && e >= 1 && e <= 3 * SY && (e - 1) % 3 == 2 && !wr_ready)
          m_stall++;
        if ((!m_active || e >= 3 * SY + 2) && start) begin
          m_active = 1; m_t = 0; m_stall = 0;
          start_cyc = cyc;
          wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
          seq.delete();
          for (int i = 0; i < SY; i++) written[i] = 0;
        end
        if (m_active && e < 1000) m_t++;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_write(input int addr, input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (cons_we === 1'b1 && cons_addr == AW'(addr)) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk({name, "_write_timeout"}, 0, 1);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < SY; i++) begin
      rnd = {$urandom, $urandom};
      mem[i] = rnd[SX-1:0];
    end
  endtask

  initial begin
    int bad, lat_a, prev_done;
    bit sent;
    Reset = 1'b1; start = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < SY; i++) mem[i] = '0;
    fork compare_loop(); join_none
    tick(); tick();
    Reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_cons_we", cons_we, 0);
    tick();

    // all-open maze
    do_start();
    wait_done("open");
    tick(); tick();
    chk("open_latency", done_cyc - start_cyc, 61);
    chk("open_writes", wr_cnt, 20);
    chk("open_busy_cycles", busy_cnt, 60);
    bad = 0;
    for (int i = 0; i < seq.size(); i++)
      if (seq[i][AW+SX-1:SX] != AW'(i) || seq[i][SX-1:0] != '0) bad++;
    chk("open_addr_order_data", bad, 0);

    // directed rows within a random maze
    rand_mem();
    mem[3] = 40'h40_0000_0000;
    mem[5] = '1;
    mem[6] = 40'h00_0000_0001;
    do_start();
    wait_done("rows");
    tick(); tick();
    chk("row3_cons", got_cons[3], 40'h80_0000_0000);
    chk("row5_cons", got_cons[5], 40'h0);
    chk("row6_cons", got_cons[6], 40'h00_0000_0002);

    // backpressure on row 10
    rand_mem();
    do_start();
    wait_write(10, "bp");
    wr_ready = 1'b0;
    repeat (4) tick();
    wr_ready = 1'b1;
    wait_done("bp");
    tick(); tick();
    chk("bp_latency", done_cyc - start_cyc, 65);
    chk("bp_busy_cycles", busy_cnt, 64);
    chk("bp_writes", wr_cnt, 20);

    // random backpressure, extra start while busy at row 12
    rand_mem();
    do_start();
    sent = 0;
    for (int i = 0; i < 600; i++) begin
      if (done === 1'b1) break;
      wr_ready = ($urandom_range(0, 3) != 0);
      if (!sent && row_rd === 1'b1 && row_addr == AW'(12)) begin
        start = 1'b1; sent = 1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0; wr_ready = 1'b1;
    tick(); tick(); tick();
    chk("busy_start_sent", sent, 1);
    chk("busy_start_writes", wr_cnt, 20);
    chk("busy_start_done_pulses", done_cnt, 1);
    bad = 0;
    for (int i = 0; i < SY; i++) if (!written[i]) bad++;
    chk("busy_start_rows_missing", bad, 0);

    // back-to-back scans
    rand_mem();
    do_start();
    wait_done("b2b_a");
    tick();
    lat_a = done_cyc - start_cyc;
    prev_done = done_cyc;
    seq_a = seq;
    do_start();
    wait_done("b2b_b");
    tick(); tick();
    chk("b2b_a_latency", lat_a, 61);
    chk("b2b_b_latency", done_cyc - start_cyc, 61);
    chk("b2b_gap", start_cyc - prev_done, 1);
    chk("b2b_len", seq.size(), seq_a.size());
    bad = 0;
    for (int i = 0; i < seq.size() && i < seq_a.size(); i++)
      if (seq[i] != seq_a[i]) bad++;
    chk("b2b_sequence", bad, 0);

    // reset mid-scan while row 7 is offered
    rand_mem();
    do_start();
    wait_write(7, "rst");
    wr_ready = 1'b0;
    Reset = 1'b1;
    tick();
    chk("midrst_cons_we", cons_we, 0);
    chk("midrst_busy", busy, 0);
    tick();
    Reset = 1'b0; wr_ready = 1'b1;
    repeat (70) tick();
    chk("midrst_row7_written", written[7], 0);
    chk("midrst_writes", wr_cnt, 7);
    chk("midrst_done_pulses", done_cnt, 0);

    // recovery scan
    do_start();
    wait_done("recover");
    tick(); tick();
    chk("recover_latency", done_cyc - start_cyc, 61);
    chk("recover_writes", wr_cnt, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
